nor_gate_checker: RTL and testbench
===================================

Name: nor_gate_checker

Overview:
Self-contained stimulus driver and response checker for the two-input NOR gate blocks.
- Drives the gate's a/b inputs through the full truth table and samples its y output after a programmable settle time.
- Compares each sample against the expected NOR value, then reports an error count, a per-vector failure map and a pass flag.
- Sits at the other end of the gate interface, replacing a hand-written initial-block bench with synthesizable, reusable check logic.

Parameters:
SETTLE_CYCLES, 2, cycles a_out/b_out are held before y_in is sampled; legal range >= 1.
LOOPS, 1, number of complete passes over the 4-vector truth table; legal range >= 1.
CNT_W, 8, width of err_count.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to begin a run; sampled only in IDLE.
y_in  input  1  output of the gate under test.
a_out  output  1  registered drive to the gate's a input.
b_out  output  1  registered drive to the gate's b input.
busy  output  1  high from the start-accept edge until DONE is entered.
done  output  1  one-cycle pulse at the end of a run.
pass  output  1  1 when the last completed run had err_count == 0; held until the next accepted start.
err_count  output  CNT_W  mismatches in the current or last run; saturates at all-ones.
fail_vec  output  4  bit i set if vector i ({a,b} = i) mismatched at least once.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs go to 0: a_out, b_out, busy, done, pass, err_count, fail_vec. Internal idx, loop count and settle count clear to 0.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE with start=1:
  - clear err_count, fail_vec and pass;
  - set idx=0, loop=0, busy=1;
  - go to DRIVE.
- IDLE with start=0: hold all outputs.
- DRIVE (1 cycle): a_out<=idx[1], b_out<=idx[0]; settle count<=0; go to SETTLE.
- SETTLE: increment settle count each cycle; go to CHECK once SETTLE_CYCLES cycles have elapsed in SETTLE. a_out/b_out are stable.
- CHECK (1 cycle): expected = ~(a_out|b_out).
  - On y_in != expected: err_count increments (saturating at 2^CNT_W-1) and fail_vec[idx] is set.
  - Next state:
    - idx<3: idx++, go to DRIVE;
    - idx==3 and loop<LOOPS-1: loop++, idx=0, go to DRIVE;
    - otherwise go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, pass=(err_count==0 including the final CHECK result);
  - a_out=b_out=0;
  - go to IDLE.
- done is high for exactly one cycle.
- Per-vector cost is SETTLE_CYCLES+2 cycles. done is high in cycle 1 + 4*LOOPS*(SETTLE_CYCLES+2) after the start-accept edge; with defaults that is cycle 17.
- Vector order per loop: {a,b} = 00, 01, 10, 11.
- start while busy is ignored, with no effect on the run in progress.
- start held high through DONE begins a new run on the first IDLE cycle.
- rst mid-run aborts immediately: no done pulse, pass=0, counters cleared.
- err_count saturation never wraps; fail_vec remains accurate after saturation.
- y_in is sampled only in CHECK; glitches in other states are ignored.

Test Plan:
1. Defaults, y_in=~(a_out|b_out) combinational; pulse start. Required:
   - a_out/b_out step 00,01,10,11;
   - done pulses once, 17 cycles after the start edge;
   - pass=1, err_count=0, fail_vec=4'b0000, busy low after done.
2. Faulty DUT y_in=a_out|b_out; pulse start. Required: err_count=4, fail_vec=4'b1111, pass=0.
3. y_in stuck at 0. Required: err_count=1, fail_vec=4'b0001, pass=0.
4. LOOPS=3, y_in stuck at 0. Required: err_count=3, done 49 cycles after start. Separately, CNT_W=2, LOOPS=4, OR DUT: err_count saturates at 3, fail_vec=4'b1111.
5. Control timing:
   - start re-pulsed while busy: no restart, done count unchanged.
   - rst asserted during vector 2: all outputs 0 the same cycle, no done.
   - A following start runs a full clean pass with pass=1.
6. SETTLE_CYCLES=1 with a 1-cycle registered correct DUT: pass=1. Same bench with a 2-cycle-delayed DUT: pass=0 and fail_vec nonzero.

Source files
------------

// File: rtl/nor_gate_checker.sv
// Stimulus driver and response checker for a two-input NOR gate.
// Walks the truth table LOOPS times and reports mismatches, per-vector failures and pass.
module nor_gate_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             y_in,
   output logic             a_out,
   output logic             b_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DRIVE  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

   logic [2:0]       state;
   logic [1:0]       idx;
   logic [LW-1:0]    loop_cnt;
   logic [SW-1:0]    settle_cnt;
   logic             mismatch;
   logic [CNT_W-1:0] err_next;

   assign mismatch = y_in ^ ~(a_out | b_out);

   // Saturating count; includes the current CHECK result so pass can use it directly.
   always_comb begin
      err_next = err_count;
      if (mismatch && (err_count != '1))
         err_next = err_count + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         a_out      <= 1'b0;
         b_out      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= '0;
         idx        <= '0;
         loop_cnt   <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  err_count <= '0;
                  fail_vec  <= '0;
                  pass      <= 1'b0;
                  idx       <= '0;
                  loop_cnt  <= '0;
                  busy      <= 1'b1;
                  state     <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               a_out      <= idx[1];
               b_out      <= idx[0];
               settle_cnt <= '0;
               state      <= S_SETTLE;
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
               if (settle_cnt == SETTLE_LAST)
                  state <= S_CHECK;
            end
            S_CHECK: begin
               err_count <= err_next;
               if (mismatch)
                  fail_vec[idx] <= 1'b1;
               if (idx != 2'd3) begin
                  idx   <= idx + 1'b1;
                  state <= S_DRIVE;
               end else if (loop_cnt != LOOP_LAST) begin
                  loop_cnt <= loop_cnt + 1'b1;
                  idx      <= '0;
                  state    <= S_DRIVE;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_next == '0);
                  a_out <= 1'b0;
                  b_out <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nor_gate_checker.sv
// Bench for nor_gate_checker: four parameterisations driven by randomized gate truth tables
// or registered gate models, checked against a truth-table-level reference model.
module tb_nor_gate_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] start_v = '0;

   always #5 clk = ~clk;

   // Gate models: instances 0-2 use an arbitrary truth table, instance 3 a pipelined NOR.
   logic [3:0] tt0 = 4'b0001, tt1 = 4'b0001, tt2 = 4'b0001;
   logic dly2 = 1'b0;
   logic r1 = 1'b1, r2 = 1'b1;

   logic a0, b0, busy0, done0, pass0; logic [7:0] err0; logic [3:0] fv0;
   logic a1, b1, busy1, done1, pass1; logic [7:0] err1; logic [3:0] fv1;
   logic a2, b2, busy2, done2, pass2; logic [1:0] err2; logic [3:0] fv2;
   logic a3, b3, busy3, done3, pass3; logic [7:0] err3; logic [3:0] fv3;
   logic y0, y1, y2, y3;

   assign y0 = tt0[{a0, b0}];
   assign y1 = tt1[{a1, b1}];
   assign y2 = tt2[{a2, b2}];
   assign y3 = dly2 ? r2 : r1;

   always @(posedge clk) begin
      r1 <= ~(a3 | b3);
      r2 <= r1;
   end

   nor_gate_checker u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .y_in(y0),
      .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_vec(fv0));

   nor_gate_checker #(.SETTLE_CYCLES(2), .LOOPS(3), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .y_in(y1),
      .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fv1));

   nor_gate_checker #(.SETTLE_CYCLES(2), .LOOPS(4), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .y_in(y2),
      .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_vec(fv2));

   nor_gate_checker #(.SETTLE_CYCLES(1), .LOOPS(1), .CNT_W(8)) u3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .y_in(y3),
      .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .fail_vec(fv3));

   int sel = 0;
   logic m_a, m_b, m_busy, m_done, m_pass;
   int m_err;
   logic [3:0] m_fv;

   always_comb begin
      m_a = a0; m_b = b0; m_busy = busy0; m_done = done0; m_pass = pass0;
      m_err = int'(err0); m_fv = fv0;
      case (sel)
         1: begin m_a = a1; m_b = b1; m_busy = busy1; m_done = done1; m_pass = pass1;
                  m_err = int'(err1); m_fv = fv1; end
         2: begin m_a = a2; m_b = b2; m_busy = busy2; m_done = done2; m_pass = pass2;
                  m_err = int'(err2); m_fv = fv2; end
         3: begin m_a = a3; m_b = b3; m_busy = busy3; m_done = done3; m_pass = pass3;
                  m_err = int'(err3); m_fv = fv3; end
         default: ;
      endcase
   end

   int passes = 0;
   int total  = 0;

   function automatic int s_of(input int w); return (w == 3) ? 1 : 2; endfunction
   function automatic int l_of(input int w);
      return (w == 1) ? 3 : (w == 2) ? 4 : 1;
   endfunction
   function automatic int w_of(input int w); return (w == 2) ? 2 : 8; endfunction

   // Reference: a NOR gate is 1 only for {a,b}=00, so the correct truth table is 4'b0001.
   function automatic void model(input logic [3:0] tt, input int which,
                                 output int e, output logic [3:0] fv, output logic p);
      int mx;
      fv = tt ^ 4'b0001;
      e  = l_of(which) * $countones(fv);
      mx = (1 << w_of(which)) - 1;
      if (e > mx) e = mx;
      p = (fv == 4'b0000);
   endfunction

   task automatic set_tt(input int which, input logic [3:0] tt);
      case (which)
         0: tt0 = tt;
         1: tt1 = tt;
         2: tt2 = tt;
         default: ;
      endcase
   endtask

   // One full run; repulse_at >= 0 re-asserts start for one cycle mid-run.
   task automatic do_run(input int which, input string name, input int exp_err,
                         input logic [3:0] exp_fv, input logic exp_pass, input int repulse_at);
      int per, cyc, done_at, exp_done;
      bit busy_ok, order_ok;
      per = s_of(which) + 2;
      exp_done = 4 * l_of(which) * per;
      sel = which;
      busy_ok = 1'b1; order_ok = 1'b1;
      @(negedge clk); start_v[which] = 1'b1;
      @(posedge clk);
      @(negedge clk); start_v[which] = 1'b0;
      cyc = 0; done_at = -1;
      while (done_at < 0 && cyc < 2000) begin
         start_v[which] = (cyc == repulse_at);
         if (m_done === 1'b1) done_at = cyc;
         else begin
            if (m_busy !== 1'b1) busy_ok = 1'b0;
            if ((cyc % per) == 1 && {m_a, m_b} !== 2'((cyc / per) % 4)) order_ok = 1'b0;
            @(negedge clk); cyc++;
         end
      end
      start_v[which] = 1'b0;
      total++;
      if (done_at !== exp_done)
         $display("FAIL %s done_cycle got %0d want %0d", name, done_at, exp_done);
      else passes++;
      total++;
      if (!busy_ok || !order_ok)
         $display("FAIL %s busy/order got busy_ok=%0d order_ok=%0d want 1 1", name, busy_ok, order_ok);
      else passes++;
      total++;
      if (m_err !== exp_err) $display("FAIL %s err_count got %0d want %0d", name, m_err, exp_err);
      else passes++;
      total++;
      if (m_fv !== exp_fv) $display("FAIL %s fail_vec got %b want %b", name, m_fv, exp_fv);
      else passes++;
      total++;
      if ({m_pass, m_busy, m_a, m_b} !== {exp_pass, 3'b000})
         $display("FAIL %s pass/busy/a/b got %b want %b", name, {m_pass, m_busy, m_a, m_b},
                  {exp_pass, 3'b000});
      else passes++;
      @(negedge clk);
      total++;
      if (m_done !== 1'b0) $display("FAIL %s done_width got %b want 0", name, m_done);
      else passes++;
   endtask

   task automatic run_model(input int which, input string name, input logic [3:0] tt);
      int e; logic [3:0] fv; logic p;
      set_tt(which, tt);
      model(tt, which, e, fv, p);
      do_run(which, name, e, fv, p, -1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sel = i; #1;
         total++;
         if ({m_a, m_b, m_busy, m_done, m_pass, m_fv} !== 9'd0 || m_err !== 0)
            $display("FAIL reset inst%0d got outs=%b err=%0d want 0", i,
                     {m_a, m_b, m_busy, m_done, m_pass, m_fv}, m_err);
         else passes++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_truth_table;
      run_model(0, "good_gate", 4'b0001);
      run_model(0, "or_gate", 4'b1110);
      run_model(0, "stuck0", 4'b0000);
      for (int i = 0; i < 6; i++) run_model(0, "rand_tt", 4'($urandom));
      set_tt(0, 4'b0001);
   endtask

   task automatic test_loops;
      run_model(1, "loops3_stuck0", 4'b0000);
      run_model(1, "loops3_rand", 4'($urandom));
      run_model(2, "sat_or", 4'b1110);
      run_model(2, "sat_rand", 4'($urandom));
   endtask

   task automatic test_busy_restart;
      bit extra;
      set_tt(0, 4'b0001);
      do_run(0, "repulse", 0, 4'b0000, 1'b1, 5);
      extra = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (m_done === 1'b1 || m_busy === 1'b1) extra = 1'b1;
      end
      total++;
      if (extra) $display("FAIL repulse_restart got extra activity want none");
      else passes++;
   endtask

   task automatic test_back_to_back;
      int cyc, d1, d2;
      sel = 0; set_tt(0, 4'b0001);
      d1 = -1; d2 = -1;
      @(negedge clk); start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc = 0;
      while (d2 < 0 && cyc < 200) begin
         if (m_done === 1'b1) begin
            if (d1 < 0) d1 = cyc; else d2 = cyc;
         end
         if (d2 < 0) begin @(negedge clk); cyc++; end
      end
      start_v[0] = 1'b0;
      total++;
      if (d1 !== 16 || d2 !== 34)
         $display("FAIL back_to_back done cycles got %0d,%0d want 16,34", d1, d2);
      else passes++;
      repeat (4) @(negedge clk);
      total++;
      if ({m_busy, m_done, m_pass} !== 3'b001)
         $display("FAIL back_to_back idle got %b want 001", {m_busy, m_done, m_pass});
      else passes++;
   endtask

   task automatic test_rst_midrun;
      bit seen;
      sel = 0; set_tt(0, 4'b0001);
      @(negedge clk); start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk); start_v[0] = 1'b0;
      repeat (9) @(negedge clk);
      total++;
      if ({m_a, m_b} !== 2'b10) $display("FAIL rst_vector2 got %b want 10", {m_a, m_b});
      else passes++;
      #1 rst = 1'b1;
      #1;
      total++;
      if ({m_a, m_b, m_busy, m_done, m_pass, m_fv} !== 9'd0 || m_err !== 0)
         $display("FAIL rst_midrun got outs=%b err=%0d want 0",
                  {m_a, m_b, m_busy, m_done, m_pass, m_fv}, m_err);
      else passes++;
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (m_done === 1'b1 || m_busy === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen) $display("FAIL rst_no_done got activity want none");
      else passes++;
      do_run(0, "after_rst", 0, 4'b0000, 1'b1, -1);
   endtask

   // Two-cycle delay shows the previous vector's NOR in CHECK; only 00->01 changes the value.
   task automatic test_registered_dut;
      dly2 = 1'b0;
      do_run(3, "reg1_dut", 0, 4'b0000, 1'b1, -1);
      dly2 = 1'b1;
      repeat (3) @(negedge clk);
      do_run(3, "reg2_dut", 1, 4'b0010, 1'b0, -1);
   endtask

   initial begin
      test_reset;
      test_truth_table;
      test_loops;
      test_busy_restart;
      test_back_to_back;
      test_rst_midrun;
      test_registered_dut;
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
